// File: rtl/ika9958_vramarb.sv
// ika9958_vramarb
// ---------------
// VRAM access-slot arbiter. Screen timing pulses i_SLOT_STB at the start of
// every free access slot. On that pulse, if either requester is waiting, this
// block grants the slot to one of them and runs exactly one VRAM transaction.
// The CPU normally wins. A starvation counter caps consecutive CPU grants
// while the command engine is waiting, so the command engine always makes
// progress.
//
// Handshake: a requester raises REQ with WR/ADDR/WDATA stable and holds it
// until its one-cycle ACK pulse. It drops REQ in the cycle after ACK. REQ is
// only sampled in the IDLE cycle that carries i_SLOT_STB. Read data is valid
// with ACK and stays in the requester's RDATA register until its next read.
//
// Ports:
//   i_EMUCLK, i_RST               clock, synchronous active-high reset
//   i_SLOT_STB                    free-slot pulse from screen timing
//   i_CPU_* / o_CPU_*             CPU request set, ACK pulse, read data
//   i_CMD_* / o_CMD_*             command-engine request set, ACK, read data
//   o_VRAM_CS/WE/ADDR/WDATA       one-cycle VRAM access strobe and payload
//   i_VRAM_RDATA                  VRAM read data, valid RD_LAT cycles after CS
//   o_BUSY                        high whenever the FSM is not IDLE
//   o_DBG_STATE, o_DBG_STARVE     FSM state and starvation counter, for debug
//
// Parameters:
//   RD_LAT  1..7   cycles from CS to valid read data
//   STARVE  1..15  consecutive CPU grants allowed while CMD is pending

module ika9958_vramarb #(
  parameter int RD_LAT = 2,
  parameter int STARVE = 3
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST,
  input  logic        i_SLOT_STB,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WR,
  input  logic [16:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_WDATA,
  output logic        o_CPU_ACK,
  output logic [7:0]  o_CPU_RDATA,
  input  logic        i_CMD_REQ,
  input  logic        i_CMD_WR,
  input  logic [16:0] i_CMD_ADDR,
  input  logic [7:0]  i_CMD_WDATA,
  output logic        o_CMD_ACK,
  output logic [7:0]  o_CMD_RDATA,
  output logic        o_VRAM_CS,
  output logic        o_VRAM_WE,
  output logic [16:0] o_VRAM_ADDR,
  output logic [7:0]  o_VRAM_WDATA,
  input  logic [7:0]  i_VRAM_RDATA,
  output logic        o_BUSY,
  output logic [1:0]  o_DBG_STATE,
  output logic [3:0]  o_DBG_STARVE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_INIT  = 3'(RD_LAT - 1);
  localparam logic [3:0] STARVE_W  = 4'(STARVE);

  state_t      state;
  logic        sel_cmd;     // latched winner: 1 = command engine
  logic        req_wr;      // latched direction of the granted request
  logic [2:0]  lat_cnt;
  logic [3:0]  starve_cnt;

  logic        any_req;
  logic        cmd_wins;

  // The command engine takes the slot when the CPU has used up its allowance
  // of consecutive grants, or when the CPU simply is not asking.
  always_comb begin
    any_req  = i_CPU_REQ | i_CMD_REQ;
    cmd_wins = i_CMD_REQ & ((starve_cnt == STARVE_W) | ~i_CPU_REQ);
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state        <= S_IDLE;
      sel_cmd      <= 1'b0;
      req_wr       <= 1'b0;
      lat_cnt      <= 3'd0;
      starve_cnt   <= 4'd0;
      o_CPU_ACK    <= 1'b0;
      o_CMD_ACK    <= 1'b0;
      o_CPU_RDATA  <= 8'd0;
      o_CMD_RDATA  <= 8'd0;
      o_VRAM_CS    <= 1'b0;
      o_VRAM_WE    <= 1'b0;
      o_VRAM_ADDR  <= 17'd0;
      o_VRAM_WDATA <= 8'd0;
      o_BUSY       <= 1'b0;
    end else begin
      // ACKs are single-cycle pulses; only the completing state raises one.
      o_CPU_ACK <= 1'b0;
      o_CMD_ACK <= 1'b0;

      case (state)
        S_IDLE: begin
          // A strobe with nobody waiting is simply dropped.
          if (i_SLOT_STB && any_req) begin
            sel_cmd      <= cmd_wins;
            req_wr       <= cmd_wins ? i_CMD_WR    : i_CPU_WR;
            o_VRAM_WE    <= cmd_wins ? i_CMD_WR    : i_CPU_WR;
            o_VRAM_ADDR  <= cmd_wins ? i_CMD_ADDR  : i_CPU_ADDR;
            o_VRAM_WDATA <= cmd_wins ? i_CMD_WDATA : i_CPU_WDATA;
            o_VRAM_CS    <= 1'b1;
            o_BUSY       <= 1'b1;
            state        <= S_ISSUE;
            // Count CPU grants only while the command engine is waiting.
            if (cmd_wins || !i_CMD_REQ)
              starve_cnt <= 4'd0;
            else if (starve_cnt != STARVE_W)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end

        S_ISSUE: begin
          o_VRAM_CS <= 1'b0;
          o_VRAM_WE <= 1'b0;
          if (req_wr) begin
            if (sel_cmd) o_CMD_ACK <= 1'b1;
            else         o_CPU_ACK <= 1'b1;
            state <= S_DONE;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (lat_cnt == 3'd0) begin
            if (sel_cmd) begin
              o_CMD_RDATA <= i_VRAM_RDATA;
              o_CMD_ACK   <= 1'b1;
            end else begin
              o_CPU_RDATA <= i_VRAM_RDATA;
              o_CPU_ACK   <= 1'b1;
            end
            state <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        S_DONE: begin
          // ACK is high this cycle; a strobe arriving now is lost.
          o_BUSY <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          o_BUSY <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_DBG_STATE  = state;
  assign o_DBG_STARVE = starve_cnt;

endmodule

// File: tb/tb_ika9958_vramarb.sv
// Testbench for ika9958_vramarb with RD_LAT=2, STARVE=3.
// Stimulus pushes expected VRAM strobes and ACKs (tagged with the cycle they
// must appear in) into queues; a monitor on the falling edge pops and checks
// them whenever the DUT asserts CS or an ACK.

module tb_ika9958_vramarb;

  localparam int RD_LAT = 2;
  localparam int STARVE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_RST = 1'b1;
  logic        i_SLOT_STB = 1'b0;
  logic        i_CPU_REQ = 1'b0, i_CPU_WR = 1'b0;
  logic [16:0] i_CPU_ADDR = '0;
  logic [7:0]  i_CPU_WDATA = '0;
  logic        i_CMD_REQ = 1'b0, i_CMD_WR = 1'b0;
  logic [16:0] i_CMD_ADDR = '0;
  logic [7:0]  i_CMD_WDATA = '0;
  logic [7:0]  i_VRAM_RDATA;
  logic        o_CPU_ACK, o_CMD_ACK, o_VRAM_CS, o_VRAM_WE, o_BUSY;
  logic [7:0]  o_CPU_RDATA, o_CMD_RDATA, o_VRAM_WDATA;
  logic [16:0] o_VRAM_ADDR;
  logic [1:0]  o_DBG_STATE;
  logic [3:0]  o_DBG_STARVE;

  ika9958_vramarb #(.RD_LAT(RD_LAT), .STARVE(STARVE)) dut (
    .i_EMUCLK(clk), .i_RST(i_RST), .i_SLOT_STB(i_SLOT_STB),
    .i_CPU_REQ(i_CPU_REQ), .i_CPU_WR(i_CPU_WR), .i_CPU_ADDR(i_CPU_ADDR),
    .i_CPU_WDATA(i_CPU_WDATA), .o_CPU_ACK(o_CPU_ACK), .o_CPU_RDATA(o_CPU_RDATA),
    .i_CMD_REQ(i_CMD_REQ), .i_CMD_WR(i_CMD_WR), .i_CMD_ADDR(i_CMD_ADDR),
    .i_CMD_WDATA(i_CMD_WDATA), .o_CMD_ACK(o_CMD_ACK), .o_CMD_RDATA(o_CMD_RDATA),
    .o_VRAM_CS(o_VRAM_CS), .o_VRAM_WE(o_VRAM_WE), .o_VRAM_ADDR(o_VRAM_ADDR),
    .o_VRAM_WDATA(o_VRAM_WDATA), .i_VRAM_RDATA(i_VRAM_RDATA), .o_BUSY(o_BUSY),
    .o_DBG_STATE(o_DBG_STATE), .o_DBG_STARVE(o_DBG_STARVE)
  );

  // Cycle counter: during a cycle, cyc holds that cycle's number.
  logic [31:0] cyc = 32'd0;

  // VRAM model: data = addr[7:0] ^ 0x3C, present only in the exact cycle
  // RD_LAT after CS; any other cycle shows 0xEE.
  logic [31:0] rd_due = 32'hFFFF_FFFF;
  logic [7:0]  rd_val = 8'h00;
  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    if (o_VRAM_CS && !o_VRAM_WE) begin
      rd_due <= cyc + RD_LAT;
      rd_val <= o_VRAM_ADDR[7:0] ^ 8'h3C;
    end
  end
  assign i_VRAM_RDATA = (cyc == rd_due) ? rd_val : 8'hEE;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [57:0] vram_q[$];   // {cycle, we, addr, wdata}
  logic [39:0] cpu_q[$];    // {cycle, rdata}
  logic [39:0] cmd_q[$];
  logic [7:0]  cpu_last = 8'h00, cmd_last = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_vram(input logic [31:0] at, input logic we, input logic [16:0] a, input logic [7:0] d);
    vram_q.push_back({at, we, a, d});
  endtask

  // ---------------- monitor ----------------
  logic [57:0] m_v;
  logic [39:0] m_a;
  always @(negedge clk) begin
    if (o_VRAM_CS) begin
      checks++;
      if (vram_q.size() == 0) begin
        errors++;
        $display("FAIL vram_cs unexpected strobe at cycle %0d addr=%0h", cyc, o_VRAM_ADDR);
      end else begin
        m_v = vram_q.pop_front();
        if ({cyc, o_VRAM_WE, o_VRAM_ADDR, o_VRAM_WDATA} !== m_v) begin
          errors++;
          $display("FAIL vram_cs actual cyc=%0d we=%0b addr=%0h wd=%0h required cyc=%0d we=%0b addr=%0h wd=%0h",
                   cyc, o_VRAM_WE, o_VRAM_ADDR, o_VRAM_WDATA,
                   m_v[57:26], m_v[25], m_v[24:8], m_v[7:0]);
        end
      end
    end
    if (o_CPU_ACK) begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_ack unexpected at cycle %0d", cyc);
      end else begin
        m_a = cpu_q.pop_front();
        if ({cyc, o_CPU_RDATA} !== m_a) begin
          errors++;
          $display("FAIL cpu_ack actual cyc=%0d rdata=%0h required cyc=%0d rdata=%0h",
                   cyc, o_CPU_RDATA, m_a[39:8], m_a[7:0]);
        end
      end
    end
    if (o_CMD_ACK) begin
      checks++;
      if (cmd_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_ack unexpected at cycle %0d", cyc);
      end else begin
        m_a = cmd_q.pop_front();
        if ({cyc, o_CMD_RDATA} !== m_a) begin
          errors++;
          $display("FAIL cmd_ack actual cyc=%0d rdata=%0h required cyc=%0d rdata=%0h",
                   cyc, o_CMD_RDATA, m_a[39:8], m_a[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Strobe during the current cycle, return in the next one.
  task automatic stb();
    i_SLOT_STB = 1'b1;
    tick();
    i_SLOT_STB = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cs"},     {31'd0, o_VRAM_CS}, 32'd0);
    chk({tag, "_we"},     {31'd0, o_VRAM_WE}, 32'd0);
    chk({tag, "_addr"},   {15'd0, o_VRAM_ADDR}, 32'd0);
    chk({tag, "_wdata"},  {24'd0, o_VRAM_WDATA}, 32'd0);
    chk({tag, "_acks"},   {30'd0, o_CPU_ACK, o_CMD_ACK}, 32'd0);
    chk({tag, "_rdata"},  {16'd0, o_CPU_RDATA, o_CMD_RDATA}, 32'd0);
    chk({tag, "_busy"},   {31'd0, o_BUSY}, 32'd0);
    chk({tag, "_state"},  {30'd0, o_DBG_STATE}, 32'd0);
    chk({tag, "_starve"}, {28'd0, o_DBG_STARVE}, 32'd0);
  endtask

  // Starvation table: grant order and starve_cnt after each grant.
  logic       win_cmd [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] starve_exp [8] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

  // ---------------- stimulus ----------------
  logic [31:0] t;
  initial begin
    ticks(3);
    check_all_zero("reset");
    i_RST = 1'b0;
    tick();

    // 1. CPU write alone.
    i_CPU_REQ = 1'b1; i_CPU_WR = 1'b1; i_CPU_ADDR = 17'h1ABCD; i_CPU_WDATA = 8'h5A;
    t = cyc;
    exp_vram(t + 1, 1'b1, 17'h1ABCD, 8'h5A);
    cpu_q.push_back({t + 32'd2, cpu_last});
    stb();
    chk("wr_busy_t1", {31'd0, o_BUSY}, 32'd1);
    tick();
    chk("wr_busy_ack", {31'd0, o_BUSY}, 32'd1);
    tick();
    i_CPU_REQ = 1'b0;
    chk("wr_busy_after", {31'd0, o_BUSY}, 32'd0);
    ticks(2);

    // 2. CMD read, data 0xFF^0x3C = 0xC3.
    i_CMD_REQ = 1'b1; i_CMD_WR = 1'b0; i_CMD_ADDR = 17'h000FF; i_CMD_WDATA = 8'h11;
    t = cyc;
    exp_vram(t + 1, 1'b0, 17'h000FF, 8'h11);
    cmd_last = 8'hC3;
    cmd_q.push_back({t + 32'd4, cmd_last});
    stb();
    ticks(4);
    i_CMD_REQ = 1'b0;
    chk("rd_cpu_rdata_held", {24'd0, o_CPU_RDATA}, {24'd0, cpu_last});
    chk("rd_cmd_rdata_held", {24'd0, o_CMD_RDATA}, 32'h0000_00C3);
    ticks(2);

    // 3. Starvation: both request writes, STB every 8 cycles.
    i_CPU_WR = 1'b1; i_CPU_ADDR = 17'h00100; i_CPU_WDATA = 8'hA0;
    i_CMD_WR = 1'b1; i_CMD_ADDR = 17'h10200; i_CMD_WDATA = 8'h50;
    i_CPU_REQ = 1'b1; i_CMD_REQ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      t = cyc;
      if (win_cmd[i]) begin
        exp_vram(t + 1, 1'b1, 17'h10200, 8'h50 + 8'(i));
        cmd_q.push_back({t + 32'd2, cmd_last});
      end else begin
        exp_vram(t + 1, 1'b1, 17'h00100, 8'hA0 + 8'(i));
        cpu_q.push_back({t + 32'd2, cpu_last});
      end
      stb();
      tick();
      chk($sformatf("starve_cnt_%0d", i), {28'd0, o_DBG_STARVE}, {28'd0, starve_exp[i]});
      tick();
      // Winner drops REQ the cycle after ACK; both pulse low together here.
      i_CPU_REQ = 1'b0; i_CMD_REQ = 1'b0;
      tick();
      i_CPU_WDATA = 8'hA0 + 8'(i + 1);
      i_CMD_WDATA = 8'h50 + 8'(i + 1);
      i_CPU_REQ = 1'b1; i_CMD_REQ = 1'b1;
      ticks(4);
    end
    i_CPU_REQ = 1'b0; i_CMD_REQ = 1'b0;
    tick();

    // 4. Slot loss: CPU read in flight, CMD write waiting.
    i_CPU_WR = 1'b0; i_CPU_ADDR = 17'h12345; i_CPU_WDATA = 8'h99;
    i_CMD_WR = 1'b1; i_CMD_ADDR = 17'h0AAAA; i_CMD_WDATA = 8'h77;
    i_CPU_REQ = 1'b1; i_CMD_REQ = 1'b1;
    t = cyc;
    exp_vram(t + 1, 1'b0, 17'h12345, 8'h99);
    cpu_last = 8'h79;
    cpu_q.push_back({t + 32'd4, cpu_last});
    stb();                                   // now T+1
    tick();                                  // T+2
    chk("loss_starve", {28'd0, o_DBG_STARVE}, 32'd1);
    stb();                                   // STB at T+2 lost, now T+3
    tick();                                  // T+4, ACK cycle
    chk("loss_busy_ack", {31'd0, o_BUSY}, 32'd1);
    stb();                                   // STB at T+4 lost, now T+5
    i_CPU_REQ = 1'b0;
    chk("loss_busy_t5", {31'd0, o_BUSY}, 32'd0);
    exp_vram(cyc + 1, 1'b1, 17'h0AAAA, 8'h77);
    cmd_q.push_back({cyc + 32'd2, cmd_last});
    stb();                                   // STB at T+5, CS at T+6
    ticks(2);
    i_CMD_REQ = 1'b0;
    chk("loss_starve_clr", {28'd0, o_DBG_STARVE}, 32'd0);
    ticks(2);

    // 5. Reset mid-read; CMD pending makes starve_cnt non-zero first.
    i_CPU_WR = 1'b0; i_CPU_ADDR = 17'h000F0; i_CPU_WDATA = 8'h00;
    i_CPU_REQ = 1'b1; i_CMD_REQ = 1'b1;
    t = cyc;
    exp_vram(t + 1, 1'b0, 17'h000F0, 8'h00);
    stb();                                   // T+1
    tick();                                  // T+2
    chk("rst_pre_starve", {28'd0, o_DBG_STARVE}, 32'd1);
    i_RST = 1'b1;
    tick();                                  // T+3
    check_all_zero("midrst");
    i_RST = 1'b0;
    cpu_last = 8'h00; cmd_last = 8'h00;
    tick();
    t = cyc;
    exp_vram(t + 1, 1'b0, 17'h000F0, 8'h00);
    cpu_last = 8'hCC;
    cpu_q.push_back({t + 32'd4, cpu_last});
    stb();
    ticks(4);
    i_CPU_REQ = 1'b0; i_CMD_REQ = 1'b0;
    chk("rst_reissue_starve", {28'd0, o_DBG_STARVE}, 32'd1);
    ticks(2);

    // 6. Idle slot: nothing requested.
    stb();
    chk("idle_busy", {31'd0, o_BUSY}, 32'd0);
    chk("idle_state", {30'd0, o_DBG_STATE}, 32'd0);
    tick();
    chk("idle_starve", {28'd0, o_DBG_STARVE}, 32'd1);
    ticks(4);

    // Everything expected must have shown up.
    chk("vram_q_empty", vram_q.size(), 32'd0);
    chk("cpu_q_empty", cpu_q.size(), 32'd0);
    chk("cmd_q_empty", cmd_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
